snoop_bus_arbiter: RTL and testbench

- Sequential arbiter and transaction sequencer for the shared 9-bit snooping bus used by the three processor caches and memory.
- Grants the bus round-robin to one processor at a time and broadcasts that processor's message as a registered bus value.
- On a read miss, holds the bus until memory replies, then broadcasts the memory reply.
- Replaces fixed-priority bus selection with fair, cycle-accurate ownership, plus a memory-timeout error path.

---
 rtl/snoop_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared 9-bit snooping bus: broadcasts one processor message
// at a time and, on a read miss, holds the bus until memory replies or times out.
module snoop_bus_arbiter #(
    parameter logic [1:0] READ_HIT    = 2'b00,
    parameter logic [1:0] READ_MISS   = 2'b01,
    parameter int         MEM_TIMEOUT = 15,
    parameter int         TW          = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [8:0] processador1,
    input  logic [8:0] processador2,
    input  logic [8:0] processador3,
    input  logic [8:0] memory,
    input  logic       mem_valid,
    output logic [2:0] grant,
    output logic [8:0] q,
    output logic       bus_valid,
    output logic       mem_req,
    output logic       timeout_err
);

    localparam logic [8:0]    IDLE_WORD  = {READ_HIT, 7'b0};
    localparam logic [TW-1:0] LAST_COUNT = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BROADCAST, WAIT_MEM, REPLY} StateT;

    StateT         r_state, w_nextState;
    logic [2:0]    r_grant, w_nextGrant;
    logic [8:0]    r_q, w_nextQ;
    logic          r_busValid, w_nextBusValid;
    logic          r_memReq, w_nextMemReq;
    logic          r_timeoutErr, w_nextTimeoutErr;
    logic [1:0]    r_lastOwner, w_nextLastOwner;
    logic [TW-1:0] r_count, w_nextCount;
    logic [1:0]    w_selIdx;
    logic [8:0]    w_selMsg;

    // Search for the next requester starting just after the previous owner.
    always_comb begin
        w_selIdx = 2'd0;
        case (r_lastOwner)
            2'd0: begin
                if (req[1])      w_selIdx = 2'd1;
                else if (req[2]) w_selIdx = 2'd2;
                else             w_selIdx = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_selIdx = 2'd2;
                else if (req[0]) w_selIdx = 2'd0;
                else             w_selIdx = 2'd1;
            end
            default: begin
                if (req[0])      w_selIdx = 2'd0;
                else if (req[1]) w_selIdx = 2'd1;
                else             w_selIdx = 2'd2;
            end
        endcase
    end

    always_comb begin
        case (w_selIdx)
            2'd0:    w_selMsg = processador1;
            2'd1:    w_selMsg = processador2;
            default: w_selMsg = processador3;
        endcase
    end

    // Every output is computed one cycle ahead and registered alongside the state.
    always_comb begin
        w_nextState      = r_state;
        w_nextGrant      = r_grant;
        w_nextQ          = IDLE_WORD;
        w_nextBusValid   = 1'b0;
        w_nextMemReq     = 1'b0;
        w_nextTimeoutErr = 1'b0;
        w_nextLastOwner  = r_lastOwner;
        w_nextCount      = '0;
        case (r_state)
            IDLE: begin
                w_nextGrant = 3'b000;
                if (req != 3'b000) begin
                    w_nextState     = BROADCAST;
                    w_nextGrant     = 3'b001 << w_selIdx;
                    w_nextQ         = w_selMsg;
                    w_nextBusValid  = 1'b1;
                    w_nextLastOwner = w_selIdx;
                end
            end
            BROADCAST: begin
                if (r_q[8:7] == READ_MISS) begin
                    w_nextState  = WAIT_MEM;
                    w_nextMemReq = 1'b1;
                end else begin
                    w_nextState = IDLE;
                    w_nextGrant = 3'b000;
                end
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    w_nextState    = REPLY;
                    w_nextQ        = memory;
                    w_nextBusValid = 1'b1;
                end else if (r_count == LAST_COUNT) begin
                    w_nextState      = IDLE;
                    w_nextGrant      = 3'b000;
                    w_nextTimeoutErr = 1'b1;
                end else begin
                    w_nextMemReq = 1'b1;
                    w_nextCount  = r_count + 1'b1;
                end
            end
            REPLY: begin
                w_nextState = IDLE;
                w_nextGrant = 3'b000;
            end
            default: begin
                w_nextState = IDLE;
                w_nextGrant = 3'b000;
            end
        endcase
    end

    // Pointer resets to P3 so that P1 wins the first arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= 3'b000;
            r_q          <= IDLE_WORD;
            r_busValid   <= 1'b0;
            r_memReq     <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_lastOwner  <= 2'd2;
            r_count      <= '0;
        end else begin
            r_state      <= w_nextState;
            r_grant      <= w_nextGrant;
            r_q          <= w_nextQ;
            r_busValid   <= w_nextBusValid;
            r_memReq     <= w_nextMemReq;
            r_timeoutErr <= w_nextTimeoutErr;
            r_lastOwner  <= w_nextLastOwner;
            r_count      <= w_nextCount;
        end
    end

    assign grant       = r_grant;
    assign q           = r_q;
    assign bus_valid   = r_busValid;
    assign mem_req     = r_memReq;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for memory timeout, reply at the timeout limit and asynchronous reset.
module tb_snoop_bus_arbiter;

    localparam logic [8:0] P1_MSG   = 9'h135;
    localparam logic [8:0] P2_MSG   = 9'h192;
    localparam logic [8:0] P3_MSG   = 9'h07F;
    localparam logic [8:0] MISS_MSG = 9'h0D0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [8:0] processador1 = 9'h000;
    logic [8:0] processador2 = 9'h000;
    logic [8:0] processador3 = 9'h000;
    logic [8:0] memory = 9'h000;
    logic       mem_valid = 1'b0;
    logic [2:0] grant;
    logic [8:0] q;
    logic       bus_valid;
    logic       mem_req;
    logic       timeout_err;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [2:0] req;
        logic [8:0] p2;
        logic       memValid;
        logic [8:0] mem;
        logic [2:0] expGrant;
        logic [8:0] expQ;
        logic       expBv;
        logic       expMr;
        logic       expTe;
    } VecT;

    VecT vecs[$];

    snoop_bus_arbiter dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .processador1(processador1),
        .processador2(processador2),
        .processador3(processador3),
        .memory(memory),
        .mem_valid(mem_valid),
        .grant(grant),
        .q(q),
        .bus_valid(bus_valid),
        .mem_req(mem_req),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    function automatic VecT mkVec(input logic [2:0] r, input logic [8:0] p2, input logic mv,
                                  input logic [8:0] m, input logic [2:0] g, input logic [8:0] qq,
                                  input logic bv, input logic mr, input logic te);
        VecT v;
        v.req = r; v.p2 = p2; v.memValid = mv; v.mem = m;
        v.expGrant = g; v.expQ = qq; v.expBv = bv; v.expMr = mr; v.expTe = te;
        return v;
    endfunction

    task automatic applyStimulus(input logic [2:0] r, input logic [8:0] p2, input logic mv,
                                 input logic [8:0] m);
        req          = r;
        processador2 = p2;
        mem_valid    = mv;
        memory       = m;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] g, input logic [8:0] qq,
                               input logic bv, input logic mr, input logic te);
        checkCount++;
        if ({grant, q, bus_valid, mem_req, timeout_err} !== {g, qq, bv, mr, te}) begin
            errorCount++;
            $display("[TB] FAIL %s: got grant=%b q=%h bv=%b mr=%b te=%b, expected grant=%b q=%h bv=%b mr=%b te=%b",
                     name, grant, q, bus_valid, mem_req, timeout_err, g, qq, bv, mr, te);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Vector table: p1 and p3 messages stay fixed, each row is one clock.
        vecs.push_back(mkVec(3'b000, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b111, P2_MSG,   1'b0, 9'h000, 3'b001, P1_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b110, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b110, P2_MSG,   1'b0, 9'h000, 3'b010, P2_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b100, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b100, P2_MSG,   1'b0, 9'h000, 3'b100, P3_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b001, P2_MSG,   1'b0, 9'h000, 3'b001, P1_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b101, P2_MSG,   1'b0, 9'h000, 3'b100, P3_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b001, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b001, P2_MSG,   1'b0, 9'h000, 3'b001, P1_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, P2_MSG,   1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b010, MISS_MSG, 1'b0, 9'h000, 3'b010, MISS_MSG, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b0, 9'h000, 3'b010, 9'h000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b0, 9'h000, 3'b010, 9'h000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b0, 9'h000, 3'b010, 9'h000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b1, 9'h0AB, 3'b010, 9'h0AB, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b0, 9'h0AB, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b1, 9'h1FF, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkVec(3'b000, MISS_MSG, 1'b0, 9'h000, 3'b000, 9'h000, 1'b0, 1'b0, 1'b0));

        // Reset held with random inputs.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("reset_async", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req          = 3'($urandom_range(0, 7));
            processador1 = 9'($urandom);
            processador3 = 9'($urandom);
            applyStimulus(req, 9'($urandom), 1'($urandom), 9'($urandom));
            step();
            checkOutput($sformatf("reset_held%0d", i), 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
        end

        processador1 = P1_MSG;
        processador3 = P3_MSG;
        applyStimulus(3'b000, P2_MSG, 1'b0, 9'h000);
        @(negedge clock);
        reset = 1'b1;
        step();
        checkOutput("idle_after_reset0", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("idle_after_reset1", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].p2, vecs[i].memValid, vecs[i].mem);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expQ,
                        vecs[i].expBv, vecs[i].expMr, vecs[i].expTe);
        end

        // Memory never answers: 15 WAIT_MEM cycles then a single error pulse.
        applyStimulus(3'b010, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("to_broadcast", 3'b010, MISS_MSG, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("to_wait0", 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) begin
            step();
            checkOutput($sformatf("to_wait%0d", k), 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        end
        step();
        checkOutput("to_pulse", 3'b000, 9'h000, 1'b0, 1'b0, 1'b1);
        step();
        checkOutput("to_after", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);

        // Reply arriving exactly on the last WAIT_MEM cycle beats the timeout.
        applyStimulus(3'b010, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("lim_broadcast", 3'b010, MISS_MSG, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("lim_wait0", 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 15; k++) begin
            step();
            checkOutput($sformatf("lim_wait%0d", k), 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(3'b000, MISS_MSG, 1'b1, 9'h155);
        step();
        checkOutput("lim_reply", 3'b010, 9'h155, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("lim_idle", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of WAIT_MEM, then P1 wins first.
        applyStimulus(3'b010, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("ar_broadcast", 3'b010, MISS_MSG, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, MISS_MSG, 1'b0, 9'h000);
        step();
        checkOutput("ar_wait0", 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("ar_wait1", 3'b010, 9'h000, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        applyStimulus(3'b111, P2_MSG, 1'b0, 9'h000);
        #1;
        checkOutput("ar_immediate", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        step();
        checkOutput("ar_p1_first", 3'b001, P1_MSG, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, P2_MSG, 1'b0, 9'h000);
        step();
        checkOutput("ar_idle", 3'b000, 9'h000, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
